// File: rtl/shifter_pkg.sv
// Shared mode encodings and FSM state type for the multi-cycle shifter.
package shifter_pkg;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single step: shifts data_i by k_i (0..STEP) per mode and reports the last bit out.
module shift_step
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = 4
) (
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   k_i,
  output logic [WIDTH-1:0] data_o,
  output logic             out_bit_o
);

  localparam int unsigned AW = SHW + 1;

  logic [AW-1:0]    wrap_amt;
  logic [SHW-1:0]   k_m1;
  logic [WIDTH-1:0] left_src;
  logic [WIDTH-1:0] right_src;

  always_comb begin
    wrap_amt  = AW'(WIDTH) - AW'(k_i);
    k_m1      = k_i - SHW'(1);
    // left_src[0] is bit WIDTH-k (zero when k==0); right_src[0] is bit k-1
    left_src  = data_i >> wrap_amt;
    right_src = data_i >> k_m1;
    data_o    = data_i;
    out_bit_o = 1'b0;
    case (mode_i)
      MODE_SLL: begin
        data_o    = data_i << k_i;
        out_bit_o = left_src[0];
      end
      MODE_SRL: begin
        data_o    = data_i >> k_i;
        out_bit_o = right_src[0];
      end
      MODE_SRA: begin
        data_o    = WIDTH'($signed(data_i) >>> k_i);
        out_bit_o = right_src[0];
      end
      default: begin
        data_o    = (data_i << k_i) | left_src;
        out_bit_o = left_src[0];
      end
    endcase
    if (k_i == '0) out_bit_o = 1'b0;
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROL), up to STEP bits per clock, Start/Busy/Done handshake.
// Define SHIFTER_CARRY_EN to add the Cout port (last bit shifted/rotated out).
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] o_o,
  output logic             busy_o,
  output logic             done_o
`ifdef SHIFTER_CARRY_EN
  ,output logic            cout_o
`endif
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] o_d;
  logic [SHW-1:0]   n_q;
  logic [1:0]       mode_q;
  logic [SHW-1:0]   amt;
  logic [SHW-1:0]   k;
  logic             step_bit;
  logic             unused_b_hi;

  assign amt         = b_i[SHW-1:0];
  assign unused_b_hi = ^b_i[WIDTH-1:SHW];
  // Amount is always < WIDTH, so k fits in SHW bits even when STEP == WIDTH
  assign k = ({1'b0, n_q} < (SHW + 1)'(STEP)) ? n_q : SHW'(STEP);

  shift_step #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_step (
    .mode_i    (mode_q),
    .data_i    (o_q),
    .k_i       (k),
    .data_o    (o_d),
    .out_bit_o (step_bit)
  );

`ifdef SHIFTER_CARRY_EN
  logic cout_q;
  assign cout_o = cout_q;
`else
  logic unused_step_bit;
  assign unused_step_bit = step_bit;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      o_q     <= '0;
      n_q     <= '0;
      mode_q  <= MODE_SLL;
`ifdef SHIFTER_CARRY_EN
      cout_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          o_q <= o_d;
          n_q <= n_q - k;
`ifdef SHIFTER_CARRY_EN
          cout_q <= step_bit;
`endif
          if (n_q == k) state_q <= DONE;
        end
        default: begin
          // IDLE and DONE accept a new operation identically
          if (start_i) begin
            o_q     <= a_i;
            n_q     <= amt;
            mode_q  <= mode_i;
`ifdef SHIFTER_CARRY_EN
            cout_q  <= 1'b0;
`endif
            state_q <= (amt != '0) ? SHIFT : DONE;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign o_o    = o_q;
  assign busy_o = (state_q == SHIFT);
  assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench: STEP=1 and STEP=4 instances driven in parallel against an arithmetic model.
module tb_seq_shifter;
  import shifter_pkg::*;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] o1, o4;
  logic         busy1, busy4, done1, done4;
`ifdef SHIFTER_CARRY_EN
  logic         cout1, cout4;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(W), .STEP(1)) u_dut1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .mode_i  (mode),
    .a_i     (a),
    .b_i     (b),
    .o_o     (o1),
    .busy_o  (busy1),
    .done_o  (done1)
`ifdef SHIFTER_CARRY_EN
    ,.cout_o (cout1)
`endif
  );

  seq_shifter #(.WIDTH(W), .STEP(4)) u_dut4 (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .mode_i  (mode),
    .a_i     (a),
    .b_i     (b),
    .o_o     (o4),
    .busy_o  (busy4),
    .done_o  (done4)
`ifdef SHIFTER_CARRY_EN
    ,.cout_o (cout4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_res(input logic [1:0] m, input logic [15:0] av, input int amt);
    int unsigned x;
    int          s;
    x = 32'(av);
    s = int'($signed(av));
    case (m)
      MODE_SLL: return 16'((x << amt) & 32'hFFFF);
      MODE_SRL: return 16'(x >> amt);
      MODE_SRA: return 16'(s >>> amt);
      default:  return 16'(((x << amt) | (x >> (16 - amt))) & 32'hFFFF);
    endcase
  endfunction

  // Last bit to leave the word over the whole operation, independent of step size
  function automatic logic model_cout(input logic [1:0] m, input logic [15:0] av, input int amt);
    int unsigned x;
    x = 32'(av);
    if (amt == 0) return 1'b0;
    if (m == MODE_SLL || m == MODE_ROL) return 1'((x >> (16 - amt)) & 1);
    return 1'((x >> (amt - 1)) & 1);
  endfunction

  task automatic run_op(input logic [1:0] m, input logic [15:0] av, input logic [15:0] bv,
                        output logic [15:0] res1, output int lat4);
    int         amt, exp1, exp4, got1, got4;
    logic [15:0] r4;
    logic       c1, c4;
    amt  = int'(bv & 16'h000F);
    exp1 = 1 + amt;
    exp4 = 1 + (amt + 3) / 4;
    got1 = 0; got4 = 0; res1 = '0; r4 = '0; c1 = 1'b0; c4 = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = m; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      if (e > 1) begin @(posedge clk); #1; end
      check("busy_done_excl", 32'(busy1 & done1), 32'd0);
      if (got1 == 0) begin
        check("busy1", 32'(busy1), (e < exp1) ? 32'd1 : 32'd0);
        if (done1) begin
          got1 = e; res1 = o1;
`ifdef SHIFTER_CARRY_EN
          c1 = cout1;
`endif
        end
      end
      if (got4 == 0 && done4) begin
        got4 = e; r4 = o4;
`ifdef SHIFTER_CARRY_EN
        c4 = cout4;
`endif
      end
      if (got1 != 0 && got4 != 0) break;
    end
    check("latency1", 32'(got1), 32'(exp1));
    check("latency4", 32'(got4), 32'(exp4));
    check("result1", 32'(res1), 32'(model_res(m, av, amt)));
    check("result4", 32'(r4), 32'(model_res(m, av, amt)));
`ifdef SHIFTER_CARRY_EN
    check("cout1", 32'(c1), 32'(model_cout(m, av, amt)));
    check("cout4", 32'(c4), 32'(model_cout(m, av, amt)));
`else
    if (c1 != c4) $display("note: carry disabled");
`endif
    lat4 = got4;
  endtask

  initial begin
    logic [15:0] r;
    int          lat4;
    int          e;
    int          ndone;
    rst = 1'b1; start = 1'b0; mode = MODE_SLL; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_o", 32'(o1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_o4", 32'(o4), 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op(MODE_SLL, 16'h0001, 16'd4, r, lat4);
    check("sll_const", 32'(r), 32'h0010);
    repeat (3) @(posedge clk);
    #1;
    check("hold_o", 32'(o1), 32'h0010);
    run_op(MODE_SRA, 16'h8000, 16'd3, r, lat4);
    check("sra_const", 32'(r), 32'hF000);
    run_op(MODE_SRL, 16'h8000, 16'd3, r, lat4);
    check("srl_const", 32'(r), 32'h1000);
    run_op(MODE_ROL, 16'h8001, 16'h0011, r, lat4);
    check("rol_const", 32'(r), 32'h0003);
    run_op(MODE_SLL, 16'h0001, 16'd15, r, lat4);
    check("step4_lat", 32'(lat4), 32'd5);
    check("step4_res", 32'(r), 32'h8000);

    // Back-to-back: Start held through DONE, second op accepted with no idle gap
    @(negedge clk);
    start = 1'b1; mode = MODE_SLL; a = 16'hBEEF; b = 16'd0;
    @(posedge clk); #1;
    check("b2b_done_a", 32'(done1), 32'd1);
    check("b2b_o_a", 32'(o1), 32'hBEEF);
    a = 16'h1234;
    @(posedge clk); #1;
    check("b2b_done_b", 32'(done1), 32'd1);
    check("b2b_o_b", 32'(o1), 32'h1234);
    start = 1'b0;
    @(posedge clk); #1;
    check("b2b_idle", 32'(done1), 32'd0);

    // Start mid-SHIFT is ignored
    @(negedge clk);
    start = 1'b1; mode = MODE_SLL; a = 16'h0001; b = 16'd8;
    @(posedge clk); #1;
    start = 1'b0; e = 1;
    repeat (2) @(posedge clk);
    e += 2;
    @(negedge clk);
    start = 1'b1; mode = MODE_SRL; a = 16'hFFFF; b = 16'd1;
    @(posedge clk); #1;
    start = 1'b0; e++;
    while (!done1 && e < 30) begin
      @(posedge clk); #1; e++;
    end
    check("ign_lat", 32'(e), 32'd9);
    check("ign_res", 32'(o1), 32'h0100);

    // Reset mid-SHIFT aborts with no Done
    @(negedge clk);
    start = 1'b1; mode = MODE_SLL; a = 16'h00FF; b = 16'd10;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    check("abort_o", 32'(o1), 32'd0);
    check("abort_busy", 32'(busy1), 32'd0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done1 || done4) ndone++;
    end
    check("abort_nodone", 32'(ndone), 32'd0);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), r, lat4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
